// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS fetch stage: PC, one-outstanding imem req/gnt/rvalid, IR hold for decode
// Optional feature macro: INSTR_FETCH_JUMP_EN (j opcode redirects next PC).
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [5:0]  if_opcode,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    input  logic        br_taken,
    input  logic [31:0] br_target
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_run;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_if_pc;
    logic [31:0] w_pc_nxt;
    logic        w_capture;
    logic        w_consume;

    // r_run keeps imem_req low through reset and its release edge without
    // a combinational path from rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_REQ;
            r_run   <= 1'b0;
            r_pc    <= RESET_PC;
            r_ir    <= 32'h0;
            r_if_pc <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
            if (w_capture) begin
                r_ir    <= imem_rdata;
                r_if_pc <= r_pc;
            end
            if (w_consume) begin
                r_pc <= w_pc_nxt;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_consume   = 1'b0;
        case (r_state)
            S_REQ: begin
                if (r_run && imem_gnt) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (if_ready) begin
                    w_consume   = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_comb begin
        w_pc_nxt = r_pc + 32'd4;
        if (br_taken) begin
            w_pc_nxt = br_target & ~32'h3;
        end
`ifdef INSTR_FETCH_JUMP_EN
        else if (r_ir[31:26] == 6'd2) begin
            w_pc_nxt = {if_pc4[31:28], r_ir[25:0], 2'b00};
        end
`endif
    end

    assign imem_req  = (r_state == S_REQ) && r_run;
    assign imem_addr = r_pc;
    assign if_valid  = (r_state == S_HOLD);
    assign if_instr  = r_ir;
    assign if_opcode = r_ir[31:26];
    assign if_pc     = r_if_pc;
    assign if_pc4    = r_if_pc + 32'd4;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the single-cycle MIPS datapath. Holds the program counter and issues one word read at a time to instruction memory over a request/grant/response handshake. Presents the fetched instruction, its PC and PC+4 to the decode stage, which includes the control unit (driven by `if_opcode`). On consumption it computes the next PC from sequential increment, taken branch or, optionally, jump.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  rising-edge clock, single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  byte address of the requested word, equal to `pc`.
- `imem_gnt`  in  1  memory accepts the request this cycle (`imem_req` & `imem_gnt`).
- `imem_rvalid`  in  1  read data valid; arrives ≥1 cycle after the grant.
- `imem_rdata`  in  32  instruction word.
- `if_valid`  out  1  `if_instr`, `if_pc` and `if_pc4` are valid.
- `if_ready`  in  1  decode/execute consumes the instruction this cycle.
- `if_instr`  out  32  held instruction.
- `if_opcode`  out  6  `if_instr[31:26]`, feeds the control unit.
- `if_pc`  out  32  address of `if_instr`.
- `if_pc4`  out  32  `if_pc + 4`, modulo 2^32.
- `br_taken`  in  1  branch resolved taken for the held instruction (control `Branch` & ALU zero).
- `br_target`  in  32  branch target; bits [1:0] ignored and forced to 0.

## Operation
- States:
  - `S_REQ`: `imem_req`=1. On `imem_gnt`, go to `S_WAIT`.
  - `S_WAIT`: `imem_req`=0. On `imem_rvalid`, capture `imem_rdata` into IR and go to `S_HOLD`.
  - `S_HOLD`: `if_valid`=1. On `if_ready`, update PC and go to `S_REQ`.
- Only one request is outstanding. `imem_addr` is stable while `imem_req` is high until it is granted.
- `imem_rvalid` outside `S_WAIT` is ignored; it does not change state or IR.
- Next PC is evaluated only on the consume event (`if_valid` & `if_ready`). Priority, highest first:
  1. `br_taken`: `{br_target[31:2],2'b00}`.
  2. Jump (see Configuration).
  3. `pc + 4`, which wraps from 32'hFFFF_FFFC to 0.
- `br_taken` and `br_target` are don't-care when no consume occurs.
- `if_instr`, `if_pc` and `if_pc4` hold their values in `S_WAIT` and `S_REQ`, but `if_valid`=0 in those states.
- Reset asserted mid-transaction aborts it immediately. A late `imem_rvalid` after reset release arrives while in `S_REQ` and is ignored.

## Timing
- Reset values:
  - state `S_REQ`, pc = `RESET_PC`.
  - `imem_req` = 0 while `rst_n`=0, then 1 in the first cycle after release.
  - `if_valid` = 0.
  - `if_instr` = 0 and `if_opcode` = 0.
  - `if_pc` = `RESET_PC`, `if_pc4` = `RESET_PC+4`.
- `imem_req`, `imem_addr` and `if_valid` are decoded from registered state only. There is no combinational path from any input to them.
- Best-case throughput is 3 cycles per instruction: grant in the request cycle, `imem_rvalid` the next cycle, consume in the first `S_HOLD` cycle.
- Each cycle of memory stall, by grant or by response, adds exactly one cycle. Each cycle `if_ready` is low adds exactly one cycle.
- The PC register updates on the clock edge of the consume cycle. The new `imem_addr` is visible in the following cycle.

## Configuration
- `INSTR_FETCH_JUMP_EN` defined:
  - On consume of an instruction with opcode 6'd2 (`j`) and `br_taken`=0, next PC = `{if_pc4[31:28], if_instr[25:0], 2'b00}`.
- Not defined:
  - Opcode 2 is treated as sequential (PC+4). The control unit's unsupported-opcode default then makes it a no-op.

## Test plan
- Reset release with `RESET_PC`=0 and memory granting immediately with 1-cycle response -> `imem_addr` sequence 0x0, 0x4, 0x8 at 3-cycle spacing, with `if_valid` pulsing in each `S_HOLD` cycle.
- `imem_gnt` held low 4 cycles, then `imem_rvalid` delayed 3 cycles -> `imem_addr` stable at 0x4 throughout the stall; `if_instr` equals the returned word 0x8C22_0004 with `if_opcode`=35.
- `if_ready` low 5 cycles in `S_HOLD` -> outputs held, `imem_req`=0, PC not advanced.
- Consume at `if_pc`=0x10 with `br_taken`=1 and `br_target`=0x43 -> next `imem_addr`=0x40.
- Instruction 0x0800_0100 at `if_pc`=0x20 -> next address 0x400 with the macro defined, 0x24 without it.
- `rst_n` pulsed low while in `S_WAIT`, with `imem_rvalid` arriving one cycle after release -> response ignored, `if_valid`=0, `imem_addr`=`RESET_PC`.
- PC wrap: `RESET_PC`=0xFFFF_FFFC, consume with `br_taken`=0 -> next `imem_addr`=0x0.
